// File: rtl/pixel_arbiter_if.sv
// Sprite request / sprite RAM / pixel output bundle for pixel_arbiter.
// slave = arbiter side, master = environment side.
interface pixel_arbiter_if #(
    parameter int ram_add_width = 8,
    parameter int num_sprites   = 4,
    parameter int color_width   = 12
);
    logic                                 clk25en;
    logic [num_sprites-1:0]               request;
    logic [num_sprites*ram_add_width-1:0] address_in;
    logic [num_sprites*2-1:0]             layer_in;
    logic [color_width-1:0]               bg_color;
    logic                                 ram_en;
    logic [ram_add_width-1:0]             ram_addr;
    logic [color_width-1:0]               ram_data;
    logic [num_sprites-1:0]               grant;
    logic [color_width-1:0]               pixel_color;
    logic                                 pixel_valid;
    logic                                 overrun;

    modport slave (
        input  clk25en, request, address_in, layer_in, bg_color, ram_data,
        output ram_en, ram_addr, grant, pixel_color, pixel_valid, overrun
    );

    modport master (
        output clk25en, request, address_in, layer_in, bg_color, ram_data,
        input  ram_en, ram_addr, grant, pixel_color, pixel_valid, overrun
    );
endinterface

// File: rtl/pixel_arbiter.sv
// Per-slot sprite pixel arbiter: picks the nearest requesting sprite, reads its color.
// Optional macro PIXEL_ARBITER_TRANSPARENCY_EN: winner color 0 shows the background.
module pixel_arbiter #(
    parameter int ram_add_width = 8,
    parameter int num_sprites   = 4,
    parameter int color_width   = 12
) (
    input logic              clk,
    input logic              resetn,
    pixel_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_slot_start;
    logic                     w_sample;
    logic                     w_found;
    logic [1:0]               w_best_layer;
    logic [num_sprites-1:0]   w_win_onehot;
    logic [ram_add_width-1:0] w_win_addr;
    logic [color_width-1:0]   w_out_color;

    logic                     r_ram_en;
    logic [ram_add_width-1:0] r_ram_addr;
    logic [num_sprites-1:0]   r_grant;
    logic [color_width-1:0]   r_pixel_color;
    logic                     r_pixel_valid;
    logic                     r_overrun;

    assign w_sample = r_slot_start && (r_state == IDLE);

    // Strict '>' keeps the lowest index on equal layers.
    always_comb begin
        w_found      = 1'b0;
        w_best_layer = '0;
        w_win_onehot = '0;
        w_win_addr   = '0;
        for (int unsigned i = 0; i < num_sprites; i++) begin
            if (bus.request[i] && (!w_found || (bus.layer_in[i*2 +: 2] > w_best_layer))) begin
                w_found         = 1'b1;
                w_best_layer    = bus.layer_in[i*2 +: 2];
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
                w_win_addr      = bus.address_in[i*ram_add_width +: ram_add_width];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_sample) w_next = READ;
            READ:    w_next = WAIT;
            WAIT:    w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_out_color = bus.bg_color;
`ifdef PIXEL_ARBITER_TRANSPARENCY_EN
        if ((|r_grant) && (bus.ram_data != '0)) w_out_color = bus.ram_data;
`else
        if (|r_grant) w_out_color = bus.ram_data;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slot_start  <= 1'b0;
            r_ram_en      <= 1'b0;
            r_ram_addr    <= '0;
            r_grant       <= '0;
            r_pixel_color <= '0;
            r_pixel_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_slot_start  <= bus.clk25en;
            r_ram_en      <= 1'b0;
            r_pixel_valid <= 1'b0;
            if (!w_sample && (|bus.request)) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_sample) begin
                        r_grant  <= w_win_onehot;
                        r_ram_en <= w_found;
                        if (w_found) r_ram_addr <= w_win_addr;
                    end
                end
                WAIT: begin
                    r_pixel_valid <= 1'b1;
                    r_pixel_color <= w_out_color;
                end
                OUT:     r_grant <= '0;
                default: ;
            endcase
        end
    end

    assign bus.ram_en      = r_ram_en;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.grant       = r_grant;
    assign bus.pixel_color = r_pixel_color;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed self-checking bench for pixel_arbiter.
module tb_pixel_arbiter;
    localparam int AW = 8;
    localparam int NS = 4;
    localparam int CW = 12;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   pv_count;

    always #5 clk = ~clk;

    pixel_arbiter_if #(.ram_add_width(AW), .num_sprites(NS), .color_width(CW)) bus ();

    pixel_arbiter #(.ram_add_width(AW), .num_sprites(NS), .color_width(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full slot: clk25en pulse, request in the sampling cycle, checks at every state.
    task automatic slot(input string tag, input logic [NS-1:0] req,
                        input logic [NS*AW-1:0] addr, input logic [NS*2-1:0] lay,
                        input logic [CW-1:0] rd, input logic [CW-1:0] bg,
                        input logic exp_en, input logic [AW-1:0] exp_addr,
                        input logic [NS-1:0] exp_g, input logic [CW-1:0] exp_c);
        bus.address_in = addr;
        bus.layer_in   = lay;
        bus.bg_color   = bg;
        bus.ram_data   = 12'h5A5;
        bus.clk25en    = 1'b1;
        cyc();
        bus.clk25en    = 1'b0;
        bus.request    = req;
        cyc();
        bus.request    = '0;
        chk({tag, ".read_en"}, bus.ram_en, exp_en);
        if (exp_en) chk({tag, ".read_addr"}, bus.ram_addr, exp_addr);
        chk({tag, ".read_grant"}, bus.grant, exp_g);
        chk({tag, ".read_pv"}, bus.pixel_valid, 1'b0);
        cyc();
        bus.ram_data = rd;
        chk({tag, ".wait_en"}, bus.ram_en, 1'b0);
        chk({tag, ".wait_grant"}, bus.grant, exp_g);
        chk({tag, ".wait_pv"}, bus.pixel_valid, 1'b0);
        cyc();
        bus.ram_data = ~rd;
        chk({tag, ".out_pv"}, bus.pixel_valid, 1'b1);
        chk({tag, ".out_color"}, bus.pixel_color, exp_c);
        chk({tag, ".out_grant"}, bus.grant, exp_g);
        cyc();
        chk({tag, ".idle_pv"}, bus.pixel_valid, 1'b0);
        chk({tag, ".idle_grant"}, bus.grant, '0);
        chk({tag, ".idle_color_hold"}, bus.pixel_color, exp_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        resetn         = 1'b0;
        bus.clk25en    = 1'b0;
        bus.request    = '0;
        bus.address_in = '0;
        bus.layer_in   = '0;
        bus.bg_color   = '0;
        bus.ram_data   = '0;
        cyc();
        cyc();
        chk("rst.ram_en", bus.ram_en, 1'b0);
        chk("rst.ram_addr", bus.ram_addr, '0);
        chk("rst.grant", bus.grant, '0);
        chk("rst.color", bus.pixel_color, '0);
        chk("rst.pv", bus.pixel_valid, 1'b0);
        chk("rst.overrun", bus.overrun, 1'b0);
        resetn = 1'b1;
        cyc();

        // Non-requesting sprites carry junk addresses and higher layers.
        slot("single", 4'b0100, 32'hAA15_BBCC, 8'b11_01_11_11, 12'hF00, 12'h111,
             1'b1, 8'h15, 4'b0100, 12'hF00);
        slot("layer", 4'b1001, 32'h3077_6610, 8'b11_10_11_01, 12'h0C3, 12'h111,
             1'b1, 8'h30, 4'b1000, 12'h0C3);
        slot("tie", 4'b1010, 32'h3100_2100, 8'b10_11_10_00, 12'h123, 12'h111,
             1'b1, 8'h21, 4'b0010, 12'h123);
        slot("all_eq", 4'b1111, 32'h4433_2211, 8'b00_00_00_00, 12'h7AB, 12'h111,
             1'b1, 8'h11, 4'b0001, 12'h7AB);
        slot("empty", 4'b0000, 32'h1234_5678, 8'b11_11_11_11, 12'hFFF, 12'h00F,
             1'b0, 8'h00, 4'b0000, 12'h00F);
`ifdef PIXEL_ARBITER_TRANSPARENCY_EN
        slot("transp", 4'b0001, 32'h0000_0009, 8'b00_00_00_00, 12'h000, 12'h0A0,
             1'b1, 8'h09, 4'b0001, 12'h0A0);
`else
        slot("transp", 4'b0001, 32'h0000_0009, 8'b00_00_00_00, 12'h000, 12'h0A0,
             1'b1, 8'h09, 4'b0001, 12'h000);
`endif
        chk("ovr.clean", bus.overrun, 1'b0);

        // Late request during WAIT: flagged, but the slot result is untouched.
        bus.address_in = 32'h3000_4200;
        bus.layer_in   = 8'b11_00_00_00;
        bus.bg_color   = 12'h000;
        bus.clk25en    = 1'b1;
        cyc();
        bus.clk25en    = 1'b0;
        bus.request    = 4'b0010;
        cyc();
        bus.request    = '0;
        chk("ovr.grant", bus.grant, 4'b0010);
        chk("ovr.addr", bus.ram_addr, 8'h42);
        cyc();
        bus.request    = 4'b1000;
        bus.ram_data   = 12'h321;
        chk("ovr.before", bus.overrun, 1'b0);
        cyc();
        bus.request    = '0;
        chk("ovr.set", bus.overrun, 1'b1);
        chk("ovr.pv", bus.pixel_valid, 1'b1);
        chk("ovr.color", bus.pixel_color, 12'h321);
        chk("ovr.grant_out", bus.grant, 4'b0010);
        chk("ovr.addr_kept", bus.ram_addr, 8'h42);
        cyc();
        cyc();
        cyc();
        chk("ovr.sticky", bus.overrun, 1'b1);
        chk("ovr.no_slot", bus.pixel_valid, 1'b0);

        // Reset asserted during READ aborts the slot.
        bus.address_in = 32'h0000_0077;
        bus.layer_in   = '0;
        bus.clk25en    = 1'b1;
        cyc();
        bus.clk25en    = 1'b0;
        bus.request    = 4'b0001;
        cyc();
        bus.request    = '0;
        chk("abort.read_en", bus.ram_en, 1'b1);
        resetn = 1'b0;
        #1;
        chk("abort.ram_en", bus.ram_en, 1'b0);
        chk("abort.ram_addr", bus.ram_addr, '0);
        chk("abort.grant", bus.grant, '0);
        chk("abort.color", bus.pixel_color, '0);
        chk("abort.pv", bus.pixel_valid, 1'b0);
        chk("abort.overrun", bus.overrun, 1'b0);
        pv_count = 0;
        cyc();
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus.pixel_valid) pv_count++;
        end
        chk("abort.no_pv", pv_count, 0);
        chk("abort.overrun_after", bus.overrun, 1'b0);

        slot("post_rst", 4'b0100, 32'h0055_0000, 8'b00_10_00_00, 12'hABC, 12'h00F,
             1'b1, 8'h55, 4'b0100, 12'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
